regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and scoreboard for the RV32I register file. It shares the file's single write port between the in-order pipeline writeback and a long-latency unit (load/mul/div) whose results are buffered in a 2-entry FIFO. It tracks busy destination registers for long-latency ops and raises a one-cycle pipeline hold to prevent starvation. It sits between the writeback stage, the long-latency unit and the register file write inputs (we, rd, write_data).

## Interface
- XLEN, 32, data width
- REG_COUNT, 32, architectural registers; AW = $clog2(REG_COUNT)
- STARVE_LIMIT, 4, consecutive blocked cycles of FIFO head before hold (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline writeback request
- pipe_rd  in  AW  pipeline destination
- pipe_data  in  XLEN  pipeline result
- lu_valid  in  1  long-unit result valid
- lu_ready  out  1  FIFO can accept
- lu_rd  in  AW  long-unit destination
- lu_data  in  XLEN  long-unit result
- sb_set  in  1  long op issued this cycle; mark sb_set_rd busy
- sb_set_rd  in  AW  destination of issued long op
- sb_rs1, sb_rs2  in  AW  source registers to query
- sb_busy1, sb_busy2  out  1  queried register has pending long-latency write
- pipe_hold  out  1  registered; stall writeback stage this cycle
- rf_we, rf_rd, rf_wdata  out  1/AW/XLEN  to register file write port

## Operation
- FIFO: 2 entries {rd, data}, count 0..2, head/tail pointers wrap mod 2. lu_ready = (count<2) && !rst. Push on lu_valid && lu_ready. Push with lu_rd==0 is accepted and dropped (not enqueued, no write).
- Grant, per cycle, combinational:
  - pipe_hold==0 && pipe_we && pipe_rd!=0: rf_we=1, rf_rd=pipe_rd, rf_wdata=pipe_data; FIFO not popped.
  - Otherwise, if count>0: rf_we=1 with FIFO head; pop at edge.
  - Otherwise rf_we=0, rf_rd=0, rf_wdata=0.
- pipe_we with pipe_rd==0 is a free slot. pipe_we while pipe_hold==1 is ignored; the stalled pipeline re-presents it.
- Push and pop allowed in the same cycle when count==1. At count==2 only pop is possible.
- Scoreboard: busy[REG_COUNT], busy[0] hard 0. At edge: set busy[sb_set_rd] if sb_set && sb_set_rd!=0; clear busy[r] when the FIFO head with rd r is popped. Same-register set and clear in one edge: set wins. Pipeline writes never clear busy.
- sb_busy1 = busy[sb_rs1], sb_busy2 = busy[sb_rs2]. Combinational from registered bits, no bypass.
- Starvation counter wait_cnt:
  - Increments each cycle count>0 and the head is not popped.
  - Clears on pop or when empty.
  - Saturates at STARVE_LIMIT.
- pipe_hold next = (wait_cnt_next == STARVE_LIMIT). While pipe_hold==1 the FIFO head is granted. This pops the head and clears wait_cnt, so the hold lasts exactly one cycle per starvation event.

## Timing
- Reset values:
  - rf_we=0, rf_rd=0, rf_wdata=0 (no pipe request, FIFO empty).
  - pipe_hold=0, lu_ready=0 during rst, then 1 in the first cycle after.
  - sb_busy1=sb_busy2=0, count=0, pointers=0, wait_cnt=0, all busy=0.
- Reset mid-operation discards FIFO contents and busy bits at that edge; no write is issued in the rst cycle from the FIFO (count forced 0 combinationally is not required; the grant uses the registered count, and rf_we from FIFO during the rst cycle is allowed but harmless only if the register file also resets).
- Pipeline write latency 0: rf_* mirror pipe_* in the same cycle; the register file commits at that edge.
- Long result pushed at edge N: earliest rf write in cycle N+1, busy cleared at edge ending N+1, sb_busy low from cycle N+2.
- Pipeline back-to-back writes for STARVE_LIMIT cycles with count>0: pipe_hold high in the next cycle, head written in that cycle, pipe_hold low after.

## Test plan
- Reset then idle: rf_we=0, pipe_hold=0, lu_ready=1 in the first post-reset cycle, sb_busy1/2=0 for all rs.
- pipe_we=1, rd=5, data=0xDEADBEEF with FIFO empty -> same cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF. Then pipe_we=1, rd=0 with FIFO empty -> rf_we=0.
- sb_set rd=7 at edge 0, lu push {7,0x1234} at edge 3, no pipe traffic -> sb_busy1(rs1=7)=1 in cycles 1..4, rf write rd=7 data 0x1234 in cycle 4, sb_busy1=0 from cycle 5.
- Push two lu results {3,0xA},{4,0xB} while pipe_we=1 every cycle -> lu_ready=0 at count 2. pipe_hold rises after 4 blocked cycles; the hold cycle writes rd=3 (0xA). The next hold writes rd=4 (0xB) four blocked cycles later. pipe_data is never written during a hold.
- count==1 with lu_valid and a free pipe slot -> push and pop in the same edge, count stays 1, data ordering preserved.
- sb_set rd=9 in the same cycle the FIFO head with rd=9 is popped -> busy[9] stays 1. lu push with rd=0 -> accepted, no rf write, count unchanged.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with a busy-register scoreboard and a one-cycle anti-starvation pipeline hold.
module regfile_wb_arbiter #(
  parameter  int XLEN         = 32,
  parameter  int REG_COUNT    = 32,
  parameter  int STARVE_LIMIT = 4,
  localparam int AW           = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_we,
  input  logic [AW-1:0]   pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [AW-1:0]   lu_rd,
  input  logic [XLEN-1:0] lu_data,
  input  logic            sb_set,
  input  logic [AW-1:0]   sb_set_rd,
  input  logic [AW-1:0]   sb_rs1,
  input  logic [AW-1:0]   sb_rs2,
  output logic            sb_busy1,
  output logic            sb_busy2,
  output logic            pipe_hold,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int WW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0]        q_rd   [2];
  logic [XLEN-1:0]      q_data [2];
  logic                 head, tail;
  logic [1:0]           count;
  logic [WW-1:0]        wait_cnt, wait_next;
  logic [REG_COUNT-1:0] busy, busy_next;
  logic                 push, pop, grant_pipe;

  assign lu_ready = (count != 2'd2) && !rst;
  assign sb_busy1 = busy[sb_rs1];
  assign sb_busy2 = busy[sb_rs2];

  always_comb begin
    // Writes to x0 from the long unit are accepted but never enqueued.
    push       = lu_valid && lu_ready && (lu_rd != '0);
    grant_pipe = !pipe_hold && pipe_we && (pipe_rd != '0);
    pop        = !grant_pipe && (count != 2'd0);

    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;
    if (grant_pipe) begin
      rf_we    = 1'b1;
      rf_rd    = pipe_rd;
      rf_wdata = pipe_data;
    end else if (pop) begin
      rf_we    = 1'b1;
      rf_rd    = q_rd[head];
      rf_wdata = q_data[head];
    end

    if ((count == 2'd0) || pop)
      wait_next = '0;
    else if (wait_cnt == WW'(STARVE_LIMIT))
      wait_next = wait_cnt;
    else
      wait_next = wait_cnt + WW'(1);

    // Clear applied before set so a same-edge set on the popped register wins.
    busy_next = busy;
    if (pop)
      busy_next[q_rd[head]] = 1'b0;
    if (sb_set && (sb_set_rd != '0))
      busy_next[sb_set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      wait_cnt  <= '0;
      pipe_hold <= 1'b0;
      busy      <= '0;
    end else begin
      if (push) begin
        q_rd[tail]   <= lu_rd;
        q_data[tail] <= lu_data;
        tail         <= ~tail;
      end
      if (pop)
        head <= ~head;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      wait_cnt  <= wait_next;
      pipe_hold <= (wait_next == WW'(STARVE_LIMIT));
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: long-unit results are queued as expected
// register-file writes and popped/compared when the arbiter grants the FIFO head.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int LIM  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_we;
  logic [AW-1:0]   pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            lu_valid;
  logic            lu_ready;
  logic [AW-1:0]   lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            sb_set;
  logic [AW-1:0]   sb_set_rd;
  logic [AW-1:0]   sb_rs1, sb_rs2;
  logic            sb_busy1, sb_busy2;
  logic            pipe_hold;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wdata;

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_COUNT(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .sb_set(sb_set), .sb_set_rd(sb_set_rd), .sb_rs1(sb_rs1), .sb_rs2(sb_rs2),
    .sb_busy1(sb_busy1), .sb_busy2(sb_busy2), .pipe_hold(pipe_hold),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t        sb_q[$];
  logic [31:0] m_busy;
  logic        m_hold;
  int unsigned m_wait;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_hold_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    sb_set = 1'b0; sb_set_rd = '0;
  endtask

  // Check outputs at the negedge against the model, advance the model, then cross the edge.
  task automatic step();
    logic        exp_pipe, pop, acc;
    int          sz;
    ent_t        e;
    int unsigned wn;
    @(negedge clk);
    if (rst) begin
      check("lu_ready_in_rst", {31'd0, lu_ready}, 32'd0);
      sb_q.delete();
      m_busy = '0; m_hold = 1'b0; m_wait = 0;
    end else begin
      sz       = sb_q.size();
      exp_pipe = !m_hold && pipe_we && (pipe_rd != '0);
      pop      = !exp_pipe && (sz > 0);
      acc      = lu_valid && (sz < 2);
      check("lu_ready", {31'd0, lu_ready}, {31'd0, (sz < 2)});
      check("pipe_hold", {31'd0, pipe_hold}, {31'd0, m_hold});
      check("sb_busy1", {31'd0, sb_busy1}, {31'd0, m_busy[sb_rs1]});
      check("sb_busy2", {31'd0, sb_busy2}, {31'd0, m_busy[sb_rs2]});
      if (pipe_hold) n_hold_seen++;
      if (exp_pipe) begin
        check("rf_we_pipe", {31'd0, rf_we}, 32'd1);
        check("rf_rd_pipe", {27'd0, rf_rd}, {27'd0, pipe_rd});
        check("rf_wdata_pipe", rf_wdata, pipe_data);
      end else if (pop) begin
        e = sb_q.pop_front();
        check("rf_we_lu", {31'd0, rf_we}, 32'd1);
        check("rf_rd_lu", {27'd0, rf_rd}, {27'd0, e.rd});
        check("rf_wdata_lu", rf_wdata, e.data);
        m_busy[e.rd] = 1'b0;
      end else begin
        check("rf_we_idle", {31'd0, rf_we}, 32'd0);
        check("rf_rd_idle", {27'd0, rf_rd}, 32'd0);
        check("rf_wdata_idle", rf_wdata, 32'd0);
      end
      if (sb_set && sb_set_rd != '0) m_busy[sb_set_rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (acc && lu_rd != '0) sb_q.push_back('{rd: lu_rd, data: lu_data});
      if (sz == 0 || pop) wn = 0;
      else wn = (m_wait == LIM) ? m_wait : m_wait + 1;
      m_wait = wn;
      m_hold = (wn == LIM);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    sb_rs1 = '0; sb_rs2 = '0;
    rst = 1'b1;
    m_busy = '0; m_hold = 1'b0; m_wait = 0; n_hold_seen = 0;
    step(); step();
    rst = 1'b0;

    // Idle after reset: every register reads not-busy.
    for (int r = 0; r < 32; r++) begin
      sb_rs1 = AW'(r); sb_rs2 = AW'(31 - r);
      step();
    end

    // Zero-latency pipeline writes; rd=0 is a free slot.
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
    step();
    pipe_rd = 5'd0; pipe_data = 32'h1111_2222;
    step();
    idle_inputs();

    // Busy lifetime: set r7, push {7,0x1234} three cycles later.
    sb_rs1 = 5'd7; sb_rs2 = 5'd0;
    sb_set = 1'b1; sb_set_rd = 5'd7;
    step();
    idle_inputs();
    step(); step();
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
    step();
    idle_inputs();
    check("busy7_during_write", {31'd0, sb_busy1}, 32'd1);
    check("lu_write_rd7", {27'd0, rf_rd}, 32'd7);
    step();
    check("busy7_cleared", {31'd0, sb_busy1}, 32'd0);
    step();

    // Starvation: two results queued behind continuous pipeline writes.
    sb_set = 1'b1; sb_set_rd = 5'd3; sb_rs1 = 5'd3; sb_rs2 = 5'd4;
    step();
    sb_set_rd = 5'd4;
    step();
    sb_set = 1'b0;
    n_hold_seen = 0;
    for (int i = 0; i < 14; i++) begin
      pipe_we = 1'b1; pipe_rd = AW'(10 + i); pipe_data = 32'hC000_0000 + 32'(i);
      lu_valid = (i < 2); lu_rd = (i == 0) ? 5'd3 : 5'd4;
      lu_data = (i == 0) ? 32'hA : 32'hB;
      step();
    end
    check("hold_events", 32'(n_hold_seen), 32'd2);
    idle_inputs();
    step(); step();

    // Simultaneous push and pop at count 1 keeps ordering.
    lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'h55;
    pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h77;
    step();
    pipe_we = 1'b0; lu_rd = 5'd13; lu_data = 32'h66;
    step();
    idle_inputs();
    step(); step();

    // Same-edge set and pop-clear on r9: set wins. Then an x0 push is dropped.
    sb_rs1 = 5'd9;
    sb_set = 1'b1; sb_set_rd = 5'd9;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    step();
    lu_valid = 1'b0;
    step();
    idle_inputs();
    check("busy9_set_wins", {31'd0, sb_busy1}, 32'd1);
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hBAD;
    step();
    idle_inputs();
    check("x0_push_no_write", {31'd0, rf_we}, 32'd0);
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pipe_we   = ($urandom_range(0, 3) != 0);
      pipe_rd   = AW'($urandom_range(0, 31));
      pipe_data = $urandom;
      lu_valid  = ($urandom_range(0, 2) == 0);
      lu_rd     = AW'($urandom_range(0, 31));
      lu_data   = $urandom;
      sb_set    = ($urandom_range(0, 3) == 0);
      sb_set_rd = AW'($urandom_range(0, 31));
      sb_rs1    = AW'($urandom_range(0, 31));
      sb_rs2    = AW'($urandom_range(0, 31));
      step();
    end

    // Reset mid-operation with a full FIFO discards contents and busy bits.
    idle_inputs();
    pipe_we = 1'b1; pipe_rd = 5'd1;
    sb_set = 1'b1; sb_set_rd = 5'd6; sb_rs1 = 5'd6;
    lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h6;
    step();
    sb_set = 1'b0; lu_rd = 5'd8; lu_data = 32'h8;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("busy6_after_rst", {31'd0, sb_busy1}, 32'd0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
